// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from a combinational-read memory
// into a DEPTH-entry circular buffer of {pc, insn}, with flush/redirect support.
module fetch_queue #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic              mem_read_en_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AWIDTH-1:0] fpc;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [AWIDTH-1:0] pc_q   [DEPTH];
  logic [DWIDTH-1:0] insn_q [DEPTH];
  logic              fetch;
  logic              pop;

  // Handshake: the head transfers on any edge where insn_valid_o && insn_ready_i;
  // valid never depends on ready, and a redirect in the same cycle drops the head.
  assign pop   = insn_valid_o && insn_ready_i;
  assign fetch = !redirect_i && ((count < CW'(DEPTH)) || pop);

  assign mem_addr_o    = fpc;
  assign mem_read_en_o = fetch;
  assign insn_valid_o  = (count != '0);
  assign insn_o        = insn_q[rd_ptr];
  assign pc_o          = pc_q[rd_ptr];
  assign count_o       = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc    <= BASEADDR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      fpc    <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        wr_ptr <= wr_ptr + PW'(1);
        fpc    <= fpc + AWIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (fetch && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !fetch) begin
        count <= count - CW'(1);
      end
    end
  end

  // Payload storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (fetch) begin
      pc_q[wr_ptr]   <= fpc;
      insn_q[wr_ptr] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, streaming, redirect, PC wrap and
// asynchronous mid-run reset, against a combinational memory model.
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr_o;
  logic        mem_read_en_o;
  logic [31:0] mem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic [2:0]  count_o;

  int n_vec;
  int n_err;

  fetch_queue #(
    .AWIDTH(32), .DWIDTH(32), .BASEADDR(32'h0100_0000), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr_o(mem_addr_o),
    .mem_read_en_o(mem_read_en_o),
    .mem_data_i(mem_data_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .insn_valid_o(insn_valid_o),
    .insn_ready_i(insn_ready_i),
    .insn_o(insn_o),
    .pc_o(pc_o),
    .count_o(count_o)
  );

  // Memory image: a NOP (addi x0,x0,0) at the base address, an address tag elsewhere.
  function automatic logic [31:0] insn_of(input logic [31:0] a);
    if (a == BASE) return 32'h0000_0013;
    return {a[15:0], 16'hC0DE};
  endfunction

  assign mem_data_i = insn_of(mem_addr_o);

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required finish before 20000");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; insn_ready_i = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d required 0", count_o); end
    n_vec++; if (insn_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", insn_valid_o); end
    n_vec++; if (mem_addr_o !== BASE) begin n_err++; $display("FAIL reset_addr: got %h required %h", mem_addr_o, BASE); end
    rst = 1'b0;
    #1;
    n_vec++; if (mem_read_en_o !== 1'b1) begin n_err++; $display("FAIL first_read_en: got %b required 1", mem_read_en_o); end
  endtask

  task automatic test_first_fetch();
    @(negedge clk); #1;
    n_vec++; if (insn_o !== 32'h0000_0013) begin n_err++; $display("FAIL first_insn: got %h required 00000013", insn_o); end
    n_vec++; if (pc_o !== BASE) begin n_err++; $display("FAIL first_pc: got %h required %h", pc_o, BASE); end
    n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL first_count: got %0d required 1", count_o); end
    n_vec++; if (mem_addr_o !== 32'h0100_0004) begin n_err++; $display("FAIL first_next_addr: got %h required 01000004", mem_addr_o); end
  endtask

  task automatic test_fill();
    insn_ready_i = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1;
      n_vec++; if (count_o !== 3'(i)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d required %0d", i, count_o, i); end
      n_vec++; if (mem_addr_o !== BASE + 32'(4 * i)) begin n_err++; $display("FAIL fill_addr[%0d]: got %h required %h", i, mem_addr_o, BASE + 32'(4 * i)); end
    end
    n_vec++; if (mem_read_en_o !== 1'b0) begin n_err++; $display("FAIL full_read_en: got %b required 0", mem_read_en_o); end
    @(negedge clk); #1;
    n_vec++; if (mem_addr_o !== 32'h0100_0010) begin n_err++; $display("FAIL full_hold_addr: got %h required 01000010", mem_addr_o); end
    n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_hold_count: got %0d required 4", count_o); end
    n_vec++; if (pc_o !== BASE) begin n_err++; $display("FAIL full_hold_pc: got %h required %h", pc_o, BASE); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    insn_ready_i = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = BASE + 32'(4 * i);
      n_vec++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL stream_pc[%0d]: got %h required %h", i, pc_o, exp_pc); end
      n_vec++; if (insn_o !== insn_of(exp_pc)) begin n_err++; $display("FAIL stream_insn[%0d]: got %h required %h", i, insn_o, insn_of(exp_pc)); end
      n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL stream_count[%0d]: got %0d required 4", i, count_o); end
      n_vec++; if (mem_read_en_o !== 1'b1) begin n_err++; $display("FAIL stream_read_en[%0d]: got %b required 1", i, mem_read_en_o); end
      n_vec++; if (mem_addr_o !== 32'h0100_0010 + 32'(4 * i)) begin n_err++; $display("FAIL stream_addr[%0d]: got %h required %h", i, mem_addr_o, 32'h0100_0010 + 32'(4 * i)); end
      @(negedge clk); #1;
    end
    insn_ready_i = 1'b0;
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h0100_0103; insn_ready_i = 1'b1;
    #1;
    n_vec++; if (mem_read_en_o !== 1'b0) begin n_err++; $display("FAIL redirect_read_en: got %b required 0", mem_read_en_o); end
    n_vec++; if (insn_valid_o !== 1'b1) begin n_err++; $display("FAIL redirect_pending_pop: got %b required 1", insn_valid_o); end
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL redirect_count: got %0d required 0", count_o); end
    n_vec++; if (insn_valid_o !== 1'b0) begin n_err++; $display("FAIL redirect_valid: got %b required 0", insn_valid_o); end
    n_vec++; if (mem_addr_o !== 32'h0100_0100) begin n_err++; $display("FAIL redirect_addr: got %h required 01000100", mem_addr_o); end
    n_vec++; if (mem_read_en_o !== 1'b1) begin n_err++; $display("FAIL redirect_refetch: got %b required 1", mem_read_en_o); end
    // ready stays high while empty; it must not underflow the count
    @(negedge clk); #1;
    n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL empty_ready_count: got %0d required 1", count_o); end
    n_vec++; if (pc_o !== 32'h0100_0100) begin n_err++; $display("FAIL redirect_head_pc: got %h required 01000100", pc_o); end
    n_vec++; if (insn_o !== insn_of(32'h0100_0100)) begin n_err++; $display("FAIL redirect_head_insn: got %h required %h", insn_o, insn_of(32'h0100_0100)); end
    insn_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    #1;
    n_vec++; if (mem_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0: got %h required fffffffc", mem_addr_o); end
    @(negedge clk); #1;
    n_vec++; if (mem_addr_o !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_addr1: got %h required 00000000", mem_addr_o); end
    n_vec++; if (pc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_head_pc: got %h required fffffffc", pc_o); end
    @(negedge clk); #1;
    n_vec++; if (mem_addr_o !== 32'h0000_0004) begin n_err++; $display("FAIL wrap_addr2: got %h required 00000004", mem_addr_o); end
    n_vec++; if (count_o !== 3'd2) begin n_err++; $display("FAIL wrap_count: got %0d required 2", count_o); end
  endtask

  task automatic test_async_reset();
    redirect_i = 1'b1; redirect_pc_i = BASE;
    @(negedge clk);
    redirect_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (count_o !== 3'd3) begin n_err++; $display("FAIL pre_rst_count: got %0d required 3", count_o); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL async_rst_count: got %0d required 0", count_o); end
    n_vec++; if (insn_valid_o !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b required 0", insn_valid_o); end
    n_vec++; if (mem_addr_o !== BASE) begin n_err++; $display("FAIL async_rst_addr: got %h required %h", mem_addr_o, BASE); end
    #1 rst = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL post_rst_count: got %0d required 1", count_o); end
    n_vec++; if (insn_o !== 32'h0000_0013) begin n_err++; $display("FAIL post_rst_insn: got %h required 00000013", insn_o); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_first_fetch();
    test_fill();
    test_stream();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 The module SHALL have parameter DWIDTH, default 32, instruction width in bits.
REQ-003 The module SHALL have parameter BASEADDR, default 32'h0100_0000, fetch PC after reset.
REQ-004 The module SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two from 2 to 16.
REQ-005 The module SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 The module SHALL have port mem_addr_o, output, AWIDTH bits, instruction memory read address.
REQ-008 The module SHALL have port mem_read_en_o, output, 1 bit, memory read enable.
REQ-009 The module SHALL have port mem_data_i, input, DWIDTH bits, memory read data, combinational in the same cycle as mem_addr_o.
REQ-010 The module SHALL have port redirect_i, input, 1 bit, flush and restart fetch.
REQ-011 The module SHALL have port redirect_pc_i, input, AWIDTH bits, new fetch PC.
REQ-012 The module SHALL have port insn_valid_o, output, 1 bit, queue head valid.
REQ-013 The module SHALL have port insn_ready_i, input, 1 bit, consumer accepts the head.
REQ-014 The module SHALL have port insn_o, output, DWIDTH bits, head instruction.
REQ-015 The module SHALL have port pc_o, output, AWIDTH bits, head instruction PC.
REQ-016 The module SHALL have port count_o, output, $clog2(DEPTH+1) bits, current occupancy.

Function
REQ-017 Internal state SHALL be a fetch PC register fpc, a DEPTH-entry circular buffer of {pc, insn}, read and write pointers, and an occupancy count.
REQ-018 mem_addr_o SHALL always equal fpc.
REQ-019 pop SHALL equal insn_valid_o AND insn_ready_i.
REQ-020 fetch SHALL equal NOT redirect_i AND (count_o < DEPTH OR pop).
REQ-021 mem_read_en_o SHALL equal fetch.
REQ-022 On a fetch cycle, the edge SHALL write {fpc, mem_data_i} at the write pointer, advance the write pointer modulo DEPTH, and set fpc to fpc + 4 modulo 2^AWIDTH.
REQ-023 On a pop cycle, the edge SHALL advance the read pointer modulo DEPTH.
REQ-024 The count SHALL change by +1 for fetch only, -1 for pop only, and 0 when both or neither occur.
REQ-025 insn_valid_o SHALL equal (count_o != 0); insn_o and pc_o SHALL show the head entry combinationally.
REQ-026 Full (count_o == DEPTH) with no pop SHALL hold fpc and the write pointer, with mem_read_en_o = 0.
REQ-027 Full with pop SHALL fetch and pop in the same cycle; count stays DEPTH.
REQ-028 Empty SHALL ignore insn_ready_i; pointers and count unchanged by it.
REQ-029 redirect_i = 1 SHALL take priority over fetch and pop: at the edge, count = 0, both pointers = 0, and fpc = {redirect_pc_i[AWIDTH-1:2], 2'b00}.
REQ-030 A head presented in a redirect cycle SHALL be discarded even if insn_ready_i = 1.
REQ-031 Latency SHALL be one cycle: an instruction fetched at edge N is visible on insn_o in the cycle after edge N.
REQ-032 fpc SHALL wrap from 2^AWIDTH - 4 to 0 without error.

Reset
REQ-033 While rst = 1, regardless of clk: fpc = BASEADDR, pointers = 0, count = 0, insn_valid_o = 0, count_o = 0, mem_addr_o = BASEADDR.
REQ-034 After rst deasserts, mem_read_en_o SHALL be 1 in the first cycle unless redirect_i = 1.
REQ-035 rst asserted mid-operation SHALL discard all queue contents immediately, asynchronously.

Verification
REQ-036 Reset, insn_ready_i = 0, DEPTH = 4 -> fetches at 0x0100_0000, 0x0100_0004, 0x0100_0008 and 0x0100_000C; count_o = 4; mem_read_en_o = 0; fpc holds 0x0100_0010.
REQ-037 Full queue, insn_ready_i = 1 steady -> one instruction per cycle; pc_o increments by 4; count_o stays 4.
REQ-038 redirect_i = 1, redirect_pc_i = 0x0100_0103, with a pending pop -> next cycle count_o = 0 and insn_valid_o = 0; the following fetch is at 0x0100_0100.
REQ-039 Memory preloaded with 0x0000_0013 at 0x0100_0000, rst deasserted -> one cycle later insn_o = 0x0000_0013 and pc_o = 0x0100_0000.
REQ-040 Redirect to 0xFFFF_FFFC -> next fetches at 0xFFFF_FFFC, then 0x0000_0000.
REQ-041 rst pulse between clock edges with count_o = 3 -> count_o = 0 and insn_valid_o = 0 immediately, before the next edge.
